// File: rtl/fetch_sequencer_if.sv
`timescale 1ns/1ps
// fetch_sequencer_if: bus bundle between the fetch sequencer and its surroundings
// (program address counter, program ROM, execute stage).
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               run;
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_inc;
  logic               load_pc;
  logic [ADDR_W-1:0]  pc_load_addr;
  logic               pc_rd_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_rd;
  logic [INSTR_W-1:0] rom_data;
  logic               rom_valid;
  logic [INSTR_W-1:0] ir_out;
  logic               ir_valid;
  logic               exec_ready;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               halted;
  logic               fetch_err;
  logic [15:0]        fetch_cnt;

  modport master (
    input  run, pc_addr, rom_data, rom_valid, exec_ready, br_taken, br_target,
    output pc_inc, load_pc, pc_load_addr, pc_rd_en, rom_addr, rom_rd,
           ir_out, ir_valid, halted, fetch_err, fetch_cnt
  );

  modport slave (
    output run, pc_addr, rom_data, rom_valid, exec_ready, br_taken, br_target,
    input  pc_inc, load_pc, pc_load_addr, pc_rd_en, rom_addr, rom_rd,
           ir_out, ir_valid, halted, fetch_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer: instruction-fetch controller for the 4-bit CPU.
// Walks ADDR -> WAIT -> INC -> ISSUE per instruction, drives the program
// address counter, reads ROM, holds the word in the instruction register and
// offers it to the execute stage. Taken branches reload the PC; HLT or a ROM
// timeout parks the sequencer in HALT until reset.
module fetch_sequencer #(
  parameter int         ADDR_W      = 8,
  parameter int         INSTR_W     = 8,
  parameter logic [3:0] HLT_OPCODE  = 4'hF,
  parameter int         ROM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset_p,
  fetch_sequencer_if.master bus
);

  localparam int TMO_W = (ROM_TIMEOUT > 1) ? $clog2(ROM_TIMEOUT) : 1;
  // Last WAIT cycle index (0-based) at which a missing rom_valid becomes an error.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ROM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_WAIT, ST_INC, ST_ISSUE, ST_BRANCH, ST_HALT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  target;
  logic [15:0]        count;
  logic               err;
  logic [3:0]         opcode;

  logic pc_inc;
  logic load_pc;
  logic pc_rd_en;
  logic rom_rd;
  logic ir_valid;
  logic halted;
  logic ir_load;
  logic tmo_clear;
  logic tmo_step;
  logic err_set;
  logic issue;
  logic target_capture;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign opcode = ir[INSTR_W-1 -: 4];

  // State register; reset returns to IDLE from anywhere, aborting any fetch.
  always_ff @(posedge clk) begin
    if (reset_p) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic and Moore strobes decoded from the current state.
  always_comb begin
    state_next     = state;
    pc_inc         = 1'b0;
    load_pc        = 1'b0;
    pc_rd_en       = 1'b0;
    rom_rd         = 1'b0;
    ir_valid       = 1'b0;
    halted         = 1'b0;
    ir_load        = 1'b0;
    tmo_clear      = 1'b0;
    tmo_step       = 1'b0;
    err_set        = 1'b0;
    issue          = 1'b0;
    target_capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.run) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        pc_rd_en   = 1'b1;
        rom_rd     = 1'b1;
        tmo_clear  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        pc_rd_en = 1'b1;
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (bus.rom_valid) begin
          ir_load    = 1'b1;
          state_next = ST_INC;
        end else if (tmo_cnt == TMO_LAST) begin
          err_set    = 1'b1;
          state_next = ST_HALT;
        end else begin
          tmo_step = 1'b1;
        end
      end
      ST_INC: begin
        pc_inc     = 1'b1;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        ir_valid = 1'b1;
        if (bus.exec_ready) begin
          issue = 1'b1;
          if (opcode == HLT_OPCODE) begin
            state_next = ST_HALT;
          end else if (bus.br_taken) begin
            target_capture = 1'b1;
            state_next     = ST_BRANCH;
          end else if (!bus.run) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_ADDR;
          end
        end
      end
      ST_BRANCH: begin
        load_pc    = 1'b1;
        state_next = bus.run ? ST_ADDR : ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Fetch address, instruction register, issue count, error flag and timeout counter.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      fetch_addr <= '0;
      ir         <= '0;
      count      <= '0;
      err        <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (rom_rd)  fetch_addr <= bus.pc_addr;
      if (ir_load) ir         <= bus.rom_data;
      if (issue)   count      <= sat_inc(count);
      if (err_set) err        <= 1'b1;
      if (tmo_clear)     tmo_cnt <= '0;
      else if (tmo_step) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Branch target is pure data: only meaningful while load_pc is high.
  always_ff @(posedge clk) begin
    if (target_capture) target <= bus.br_target;
  end

  assign bus.pc_inc       = pc_inc;
  assign bus.load_pc      = load_pc;
  assign bus.pc_load_addr = load_pc ? target : '0;
  assign bus.pc_rd_en     = pc_rd_en;
  assign bus.rom_addr     = fetch_addr;
  assign bus.rom_rd       = rom_rd;
  assign bus.ir_out       = ir;
  assign bus.ir_valid     = ir_valid;
  assign bus.halted       = halted;
  assign bus.fetch_err    = err;
  assign bus.fetch_cnt    = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// tb_fetch_sequencer: directed bench with a program-level reference model
// (expected fetch address, issued word, issue count, halt) checked every cycle.
module tb_fetch_sequencer;

  logic clk;
  logic reset_p;

  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  fetch_sequencer #(
    .ADDR_W(8), .INSTR_W(8), .HLT_OPCODE(4'hF), .ROM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;
  int cyc;

  // Environment: program ROM, program address counter.
  logic [7:0] mem [256];
  logic [7:0] pc;
  logic       pc_wr;
  logic [7:0] pc_wr_val;
  logic       rom_v;
  logic [7:0] rom_d;
  logic       spur;
  int         rom_lat;
  logic       rom_mute;

  assign bus.pc_addr   = pc;
  assign bus.rom_valid = rom_v | spur;
  assign bus.rom_data  = rom_d;

  always @(posedge clk) begin
    if (pc_wr)            pc <= pc_wr_val;
    else if (bus.load_pc) pc <= bus.pc_load_addr;
    else if (bus.pc_inc)  pc <= pc + 8'd1;
  end

  // ROM: answers a read request rom_lat cycles later (1 = first WAIT cycle).
  initial begin
    logic       req;
    logic [7:0] req_addr;
    logic [7:0] hold_addr;
    int         left;
    rom_v = 1'b0;
    rom_d = 8'h00;
    left  = 0;
    hold_addr = 8'h00;
    forever begin
      @(negedge clk);
      req      = bus.rom_rd;
      req_addr = bus.pc_addr;
      @(posedge clk);
      #1;
      if (req && !rom_mute) begin
        left      = rom_lat;
        hold_addr = req_addr;
      end
      rom_v = 1'b0;
      if (left == 1) begin
        rom_v = 1'b1;
        rom_d = mem[hold_addr];
        left  = 0;
      end else if (left > 1) begin
        left--;
      end
    end
  end

  // Reference model state.
  logic [7:0]  exp_addr;
  logic [15:0] exp_cnt;
  logic        exp_halt;
  logic        exp_br;
  logic        prev_rst;
  logic        prev_rd;
  logic        hold_v;
  logic [7:0]  hold_ir;
  int          inc_since;
  int          inc_total;
  int          load_total;
  int          rd_total;
  logic [7:0]  last_load;
  logic [7:0]  issued_w [$];
  int          issued_c [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_compare();
    logic [7:0] w;
    if (reset_p) begin
      exp_cnt   = 16'h0000;
      exp_halt  = 1'b0;
      exp_br    = 1'b0;
      hold_v    = 1'b0;
      inc_since = 0;
      prev_rd   = 1'b0;
      prev_rst  = 1'b1;
      if (pc_wr) exp_addr = pc_wr_val;
      return;
    end
    if (prev_rst) begin
      chk("reset_strobes", {bus.pc_inc, bus.load_pc, bus.pc_rd_en, bus.rom_rd,
                            bus.ir_valid, bus.halted, bus.fetch_err}, 0);
      chk("reset_ir", bus.ir_out, 0);
      chk("reset_cnt", bus.fetch_cnt, 0);
      chk("reset_addrs", {bus.rom_addr, bus.pc_load_addr}, 0);
    end
    prev_rst = 1'b0;
    chk("inc_load_excl", bus.pc_inc & bus.load_pc, 0);
    chk("fetch_cnt", bus.fetch_cnt, exp_cnt);
    if (exp_halt)
      chk("halt_quiet", {bus.halted, bus.pc_inc, bus.load_pc, bus.rom_rd, bus.ir_valid}, 5'b10000);
    if (prev_rd) begin
      chk("rom_addr", bus.rom_addr, exp_addr);
      chk("branch_load_seen", exp_br, 0);
    end
    if (bus.load_pc) begin
      chk("load_expected", exp_br, 1);
      chk("load_addr", bus.pc_load_addr, exp_addr);
      exp_br    = 1'b0;
      load_total++;
      last_load = bus.pc_load_addr;
    end
    if (bus.pc_inc) begin
      inc_since++;
      inc_total++;
    end
    if (bus.rom_rd) rd_total++;
    if (hold_v && bus.ir_valid) chk("ir_stable", bus.ir_out, hold_ir);
    if (bus.ir_valid && bus.exec_ready) begin
      w = mem[exp_addr];
      chk("ir_word", bus.ir_out, w);
      chk("inc_per_instr", inc_since, 1);
      inc_since = 0;
      exp_cnt   = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      issued_w.push_back(bus.ir_out);
      issued_c.push_back(cyc);
      if (w[7:4] == 4'hF) begin
        exp_halt = 1'b1;
      end else if (bus.br_taken) begin
        exp_br   = 1'b1;
        exp_addr = bus.br_target;
      end else begin
        exp_addr = exp_addr + 8'd1;
      end
    end
    hold_v  = bus.ir_valid && !bus.exec_ready;
    hold_ir = bus.ir_out;
    prev_rd = bus.rom_rd;
    if (pc_wr) exp_addr = pc_wr_val;
  endtask

  task automatic tick();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [7:0] start);
    reset_p   = 1'b1;
    bus.run   = 1'b0;
    pc_wr     = 1'b1;
    pc_wr_val = start;
    tick();
    reset_p = 1'b0;
    pc_wr   = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.ir_valid && n < 60) begin
      tick();
      n++;
    end
    chk("issue_wait", bus.ir_valid, 1);
  endtask

  task automatic issue_one(input logic r, input logic b, input logic [7:0] t);
    wait_valid();
    bus.run        = r;
    bus.br_taken   = b;
    bus.br_target  = t;
    bus.exec_ready = 1'b1;
    tick();
    bus.br_taken  = 1'b0;
    bus.br_target = 8'h00;
  endtask

  task automatic wait_rd();
    int n;
    n = 0;
    while (!bus.rom_rd && n < 20) begin
      tick();
      n++;
    end
    chk("rd_wait", bus.rom_rd, 1);
  endtask

  initial begin
    int n;
    int base;
    checks = 0; errors = 0; cyc = 0;
    exp_addr = 8'h00; exp_cnt = 16'h0; exp_halt = 1'b0; exp_br = 1'b0;
    prev_rst = 1'b0; prev_rd = 1'b0; hold_v = 1'b0; hold_ir = 8'h00;
    inc_since = 0; inc_total = 0; load_total = 0; rd_total = 0; last_load = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h20;
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h77;
    mem[8'hA0] = 8'h5A; mem[8'hA1] = 8'hF3;
    mem[8'h30] = 8'h3C; mem[8'h31] = 8'h4D;
    mem[8'h40] = 8'h9E;
    mem[8'hFF] = 8'h61; mem[8'h00] = 8'h62;
    bus.run = 1'b0; bus.exec_ready = 1'b1; bus.br_taken = 1'b0; bus.br_target = 8'h00;
    spur = 1'b0; rom_lat = 1; rom_mute = 1'b0;
    reset_p = 1'b1; pc_wr = 1'b1; pc_wr_val = 8'h10;

    // Sequential fetch of 12, 34, 56
    do_reset(8'h10);
    bus.run = 1'b1;
    base = inc_total;
    issued_w.delete(); issued_c.delete();
    issue_one(1'b1, 1'b0, 8'h00);
    issue_one(1'b1, 1'b0, 8'h00);
    issue_one(1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    chk("t1_issued", issued_w.size(), 3);
    if (issued_w.size() == 3) begin
      chk("t1_w0", issued_w[0], 8'h12);
      chk("t1_w1", issued_w[1], 8'h34);
      chk("t1_w2", issued_w[2], 8'h56);
      chk("t1_gap01", issued_c[1] - issued_c[0], 4);
      chk("t1_gap12", issued_c[2] - issued_c[1], 4);
    end
    chk("t1_pc_inc", inc_total - base, 3);
    chk("t1_fetch_cnt", bus.fetch_cnt, 3);

    // Taken branch to A0
    base = load_total;
    issued_w.delete(); issued_c.delete();
    bus.run = 1'b1;
    issue_one(1'b1, 1'b1, 8'hA0);
    issue_one(1'b1, 1'b0, 8'h00);
    chk("t2_issued", issued_w.size(), 2);
    if (issued_w.size() == 2) begin
      chk("t2_w0", issued_w[0], 8'h77);
      chk("t2_w1", issued_w[1], 8'h5A);
      chk("t2_gap", issued_c[1] - issued_c[0], 5);
    end
    chk("t2_loads", load_total - base, 1);
    chk("t2_load_addr", last_load, 8'hA0);

    // HLT issued with br_taken set
    issue_one(1'b1, 1'b1, 8'h55);
    spur = 1'b1;
    bus.run = 1'b1;
    repeat (6) tick();
    spur = 1'b0;
    chk("t3_halted", bus.halted, 1);
    chk("t3_no_load", load_total - base, 1);
    chk("t3_ir", bus.ir_out, 8'hF3);
    chk("t3_fetch_cnt", bus.fetch_cnt, 6);

    // Execute stage stalls for 5 cycles
    do_reset(8'h30);
    bus.exec_ready = 1'b0;
    bus.run = 1'b1;
    wait_valid();
    base = rd_total;
    issued_w.delete(); issued_c.delete();
    repeat (5) begin
      tick();
      chk("t4_hold_valid", bus.ir_valid, 1);
      chk("t4_hold_ir", bus.ir_out, 8'h3C);
    end
    chk("t4_no_reads", rd_total - base, 0);
    bus.run = 1'b0;
    bus.exec_ready = 1'b1;
    tick();
    repeat (6) tick();
    chk("t4_one_issue", issued_w.size(), 1);
    chk("t4_fetch_cnt", bus.fetch_cnt, 1);
    chk("t4_idle", bus.ir_valid, 0);

    // ROM never answers
    rom_mute = 1'b1;
    do_reset(8'h40);
    bus.run = 1'b1;
    wait_rd();
    n = 0;
    while (!bus.halted && n < 40) begin
      tick();
      n++;
    end
    chk("t5_timeout_cycles", n, 16);
    chk("t5_err", bus.fetch_err, 1);
    chk("t5_cnt", bus.fetch_cnt, 0);

    // ROM answers on the 15th WAIT cycle
    rom_mute = 1'b0;
    rom_lat = 15;
    do_reset(8'h40);
    chk("t5_err_cleared", bus.fetch_err, 0);
    bus.run = 1'b1;
    wait_rd();
    n = 0;
    while (!bus.ir_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t5_late_cycles", n, 17);
    issued_w.delete(); issued_c.delete();
    issue_one(1'b0, 1'b0, 8'h00);
    chk("t5_late_err", bus.fetch_err, 0);
    chk("t5_late_cnt", bus.fetch_cnt, 1);
    chk("t5_late_word", (issued_w.size() == 1) ? issued_w[0] : 8'hXX, 8'h9E);

    // PC wrap FF -> 00
    rom_lat = 1;
    do_reset(8'hFF);
    issued_w.delete(); issued_c.delete();
    bus.run = 1'b1;
    issue_one(1'b1, 1'b0, 8'h00);
    issue_one(1'b0, 1'b0, 8'h00);
    chk("t6_issued", issued_w.size(), 2);
    if (issued_w.size() == 2) begin
      chk("t6_w0", issued_w[0], 8'h61);
      chk("t6_w1", issued_w[1], 8'h62);
    end
    chk("t6_rom_addr", bus.rom_addr, 8'h00);

    // Reset during WAIT
    rom_lat = 5;
    do_reset(8'h50);
    bus.run = 1'b1;
    wait_rd();
    tick();
    tick();
    chk("t6_in_wait", {bus.pc_rd_en, bus.rom_rd}, 2'b10);
    reset_p = 1'b1;
    bus.run = 1'b0;
    tick();
    reset_p = 1'b0;
    chk("t6_rst_strobes", {bus.pc_inc, bus.load_pc, bus.pc_rd_en, bus.rom_rd,
                           bus.ir_valid, bus.halted, bus.fetch_err}, 0);
    chk("t6_rst_ir", bus.ir_out, 0);
    repeat (6) tick();
    chk("t6_late_rom_ignored", bus.ir_out, 0);
    chk("t6_idle_cnt", bus.fetch_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
